dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the single-port, word-wide data memory between two masters: m0 (core load/store path) and m1 (debug/DMA).
// - Sequences sub-word stores as read-modify-write (RMW); full-word accesses are single-shot.
// - Gives each master a stall (hold) signal.
// - Sits between the core memory-access stage plus the debug master and the synchronous data RAM.
// PARAMETERS
// RR_EN      1   1: round-robin between m0/m1; 0: fixed priority, m0 always wins
// ADDR_W     32  byte-address width
// PORTS
// clk          in   1       core clock
// rst_n        in   1       asynchronous active-low reset
// mX_req_i     in   1       request (X = 0,1); held high until mX_ack_o
// mX_we_i      in   1       1 = write, 0 = read
// mX_addr_i    in   ADDR_W  byte address; [1:0] ignored (word aligned)
// mX_wdata_i   in   32      write data, lane-positioned (byte k in [8k+7:8k])
// mX_strb_i    in   4       byte-lane write enables; ignored for reads
// mX_ack_o     out  1       one-cycle completion pulse
// mX_rdata_o   out  32      read word, valid only while mX_ack_o=1 on a read, else 0
// mX_hold_o    out  1       mX_req_i & ~mX_ack_o (pipeline stall)
// mem_req_o    out  1       RAM access strobe
// mem_we_o     out  1       RAM write enable
// mem_addr_o   out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
// mem_wdata_o  out  32      RAM write word
// mem_rdata_i  in   32      RAM read word, valid the cycle after a read strobe
// busy_o       out  1       state != IDLE
// BEHAVIOUR
// - States: IDLE, RESP, RMW. Async reset -> IDLE, last_owner=m1. Every registered output 0; while rst_n=0 all mem_* outputs are 0.
// - IDLE, no req: all mem_* outputs 0.
// - IDLE, any req: arbitrate combinationally.
//   - Both requesting: RR_EN=1 grants the master that is not last_owner; RR_EN=0 grants m0.
//   - The winner's we/addr/wdata/strb and owner id are latched; last_owner <= winner.
//   - Request drives memory the same cycle as the grant:
//     - read: mem_req=1, we=0 -> RESP
//     - write, strb=4'hF: mem_req=1, we=1, wdata=mX_wdata -> RESP
//     - write, strb=0: no mem access -> RESP (no-op write)
//     - write, other strb: mem_req=1, we=0 (fetch old word) -> RMW
// - RESP: owner ack=1. On a read, owner rdata = mem_rdata_i. -> IDLE.
// - RMW: mem_req=1, we=1, latched addr.
//   - mem_wdata lane k = strb[k] ? wdata lane k : mem_rdata_i lane k.
//   - owner ack=1 -> IDLE.
// - Latency: grant to ack is always exactly 1 cycle. There is one IDLE cycle between back-to-back transactions.
// - Masters are re-sampled only in IDLE. Request changes after the grant are ignored. A req dropped before ack still completes and acks.
// - A non-owner requesting during RESP/RMW sees hold=1, ack=0, and no memory activity.
// - Only the owner's ack/rdata ever assert. Acks never pulse for both masters in one cycle.
// - Reset asserted in RESP/RMW: the in-flight transaction is dropped. No ack and no RAM write happen, including when reset lands in the RMW cycle.
// TESTING
// - RAM[0x100]=0xDEADBEEF, m0 read 0x100 at t0 -> t0 mem_req=1 we=0 hold=1; t1 m0_ack=1 rdata=0xDEADBEEF hold=0.
// - RAM[0x40]=0x11223344, m0 write strb=4'b0100 wdata=0x00AA0000 -> t0 read 0x40; t1 we=1 wdata=0x11AA3344 ack=1.
// - From reset, m0 and m1 read together with RR_EN=1 -> m0 acked t1, m1 granted t2 and acked t3; repeat both -> m1 served first.
// - RR_EN=0, m0 requests back-to-back for 20 transactions while m1 requests -> m1_ack never asserts, m1_hold stays 1.
// - m1 write strb=0 -> no mem_req in any cycle, m1_ack=1 at t1; RAM unchanged.
// - Partial write, rst_n low in the RMW cycle -> mem_we_o=0 immediately, no ack, busy_o=0; RAM word unchanged.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-master data-memory arbiter with read-modify-write for sub-word stores
module dmem_port_arbiter #(
  parameter bit RR_EN  = 1'b1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  input  logic [3:0]        m0_strb_i,
  output logic              m0_ack_o,
  output logic [31:0]       m0_rdata_o,
  output logic              m0_hold_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  input  logic [3:0]        m1_strb_i,
  output logic              m1_ack_o,
  output logic [31:0]       m1_rdata_o,
  output logic              m1_hold_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, RESP, RMW} state_t;

  state_t            state;
  logic              owner;
  logic              last_owner;
  logic              we_q;
  logic [ADDR_W-1:2] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;

  logic              any_req;
  logic              grant1;
  logic              sel_we;
  logic [ADDR_W-1:2] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_strb;
  logic              ack;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

  // m1 wins only when alone, or under round-robin when m0 was served last
  assign any_req   = m0_req_i | m1_req_i;
  assign grant1    = m1_req_i & (~m0_req_i | (RR_EN & ~last_owner));
  assign sel_we    = grant1 ? m1_we_i                 : m0_we_i;
  assign sel_addr  = grant1 ? m1_addr_i[ADDR_W-1:2]   : m0_addr_i[ADDR_W-1:2];
  assign sel_wdata = grant1 ? m1_wdata_i              : m0_wdata_i;
  assign sel_strb  = grant1 ? m1_strb_i               : m0_strb_i;

  assign ack       = (state == RESP) || (state == RMW);
  assign m0_ack_o  = ack & ~owner;
  assign m1_ack_o  = ack & owner;
  assign m0_hold_o = m0_req_i & ~m0_ack_o;
  assign m1_hold_o = m1_req_i & ~m1_ack_o;
  assign busy_o    = (state != IDLE);

  assign m0_rdata_o = (m0_ack_o && state == RESP && !we_q) ? mem_rdata_i : 32'h0;
  assign m1_rdata_o = (m1_ack_o && state == RESP && !we_q) ? mem_rdata_i : 32'h0;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          // a write with no lanes enabled never touches the RAM
          if (any_req && (!sel_we || sel_strb != 4'h0)) begin
            mem_req_o  = 1'b1;
            mem_addr_o = {sel_addr, 2'b00};
            if (sel_we && sel_strb == 4'hF) begin
              mem_we_o    = 1'b1;
              mem_wdata_o = sel_wdata;
            end
          end
        end
        RMW: begin
          mem_req_o  = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = {addr_q, 2'b00};
          for (int k = 0; k < 4; k++) begin
            mem_wdata_o[8*k +: 8] = strb_q[k] ? wdata_q[8*k +: 8] : mem_rdata_i[8*k +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      strb_q     <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= grant1;
            last_owner <= grant1;
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            strb_q     <= sel_strb;
            state      <= (sel_we && sel_strb != 4'hF && sel_strb != 4'h0) ? RMW : RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_strb, m1_strb;
  logic        m0_ack, m0_hold, m1_ack, m1_hold, mem_req, mem_we, busy;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        fp_m0_ack, fp_m0_hold, fp_m1_ack, fp_m1_hold, fp_mem_req, fp_mem_we, fp_busy;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata;
  logic [31:0] ram [0:255];

  int n_cmp = 0;
  int n_bad = 0;
  int fp_acks;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.RR_EN(1'b1), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_strb_i(m0_strb),
    .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata), .m0_hold_o(m0_hold),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_strb_i(m1_strb),
    .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata), .m1_hold_o(m1_hold),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  dmem_port_arbiter #(.RR_EN(1'b0), .ADDR_W(32)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_strb_i(m0_strb),
    .m0_ack_o(fp_m0_ack), .m0_rdata_o(fp_m0_rdata), .m0_hold_o(fp_m0_hold),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_strb_i(m1_strb),
    .m1_ack_o(fp_m1_ack), .m1_rdata_o(fp_m1_rdata), .m1_hold_o(fp_m1_hold),
    .mem_req_o(fp_mem_req), .mem_we_o(fp_mem_we), .mem_addr_o(fp_mem_addr), .mem_wdata_o(fp_mem_wdata),
    .mem_rdata_i(32'h0), .busy_o(fp_busy)
  );

  always @(posedge clk) begin
    if (preload) begin
      ram[8'h40] <= 32'hDEADBEEF;
      ram[8'h10] <= 32'h11223344;
      ram[8'h20] <= 32'h00000000;
      mem_rdata  <= 32'h0;
    end else if (mem_req) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        t0_req, t0_we, t1_req, t1_we;
    logic [31:0] t1_wdata;
    logic [31:0] rdata;
    logic [31:0] word;
  } vec_t;

  vec_t v [7];

  function automatic vec_t mk(logic mst, logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] strb,
                              logic t0_req, logic t0_we, logic t1_req, logic t1_we,
                              logic [31:0] t1_wdata, logic [31:0] rdata, logic [31:0] word);
    vec_t r;
    r.mst = mst; r.we = we; r.addr = addr; r.wdata = wdata; r.strb = strb;
    r.t0_req = t0_req; r.t0_we = t0_we; r.t1_req = t1_req; r.t1_we = t1_we;
    r.t1_wdata = t1_wdata; r.rdata = rdata; r.word = word;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic mst, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb);
    if (mst) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_strb = strb;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_strb = strb;
    end
  endtask

  initial begin
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_wdata = 32'h0; m0_strb = 4'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0;   m1_wdata = 32'h0; m1_strb = 4'h0;

    v[0] = mk(1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
    v[1] = mk(1'b0, 1'b1, 32'h040, 32'h00AA0000, 4'h4, 1, 0, 1, 1, 32'h11AA3344, 32'h0,        32'h11AA3344);
    v[2] = mk(1'b1, 1'b1, 32'h080, 32'hCAFEF00D, 4'hF, 1, 1, 0, 0, 32'h0,        32'h0,        32'hCAFEF00D);
    v[3] = mk(1'b1, 1'b1, 32'h102, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hDEADBEEF);
    v[4] = mk(1'b1, 1'b0, 32'h081, 32'h0,        4'hF, 1, 0, 0, 0, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D);
    v[5] = mk(1'b1, 1'b1, 32'h040, 32'h55000066, 4'h9, 1, 0, 1, 1, 32'h55AA3366, 32'h0,        32'h55AA3366);
    v[6] = mk(1'b0, 1'b0, 32'h043, 32'h0,        4'h0, 1, 0, 0, 0, 32'h0,        32'h55AA3366, 32'h55AA3366);

    // reset held with a pending request: nothing may reach the RAM
    #1;
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_m0_ack", {31'h0, m0_ack}, 32'h0);
    tick; tick;
    m0_req = 1'b0;
    preload = 1'b0;
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 7; i++) begin
      drive(v[i].mst, v[i].we, v[i].addr, v[i].wdata, v[i].strb);
      #1;
      check($sformatf("v%0d_t0_mem_req", i), {31'h0, mem_req}, {31'h0, v[i].t0_req});
      check($sformatf("v%0d_t0_mem_we", i), {31'h0, mem_we}, {31'h0, v[i].t0_we});
      if (v[i].t0_req)
        check($sformatf("v%0d_t0_mem_addr", i), mem_addr, {v[i].addr[31:2], 2'b00});
      check($sformatf("v%0d_t0_hold", i), {31'h0, (v[i].mst ? m1_hold : m0_hold)}, 32'h1);
      check($sformatf("v%0d_t0_busy", i), {31'h0, busy}, 32'h0);
      tick;
      check($sformatf("v%0d_t1_ack", i), {31'h0, (v[i].mst ? m1_ack : m0_ack)}, 32'h1);
      check($sformatf("v%0d_t1_other_ack", i), {31'h0, (v[i].mst ? m0_ack : m1_ack)}, 32'h0);
      check($sformatf("v%0d_t1_hold", i), {31'h0, (v[i].mst ? m1_hold : m0_hold)}, 32'h0);
      check($sformatf("v%0d_t1_rdata", i), (v[i].mst ? m1_rdata : m0_rdata), v[i].rdata);
      check($sformatf("v%0d_t1_mem_req", i), {31'h0, mem_req}, {31'h0, v[i].t1_req});
      check($sformatf("v%0d_t1_mem_we", i), {31'h0, mem_we}, {31'h0, v[i].t1_we});
      if (v[i].t1_we)
        check($sformatf("v%0d_t1_mem_wdata", i), mem_wdata, v[i].t1_wdata);
      check($sformatf("v%0d_t1_busy", i), {31'h0, busy}, 32'h1);
      m0_req = 1'b0;
      m1_req = 1'b0;
      tick;
      check($sformatf("v%0d_idle_busy", i), {31'h0, busy}, 32'h0);
      check($sformatf("v%0d_ram_word", i), ram[v[i].addr[9:2]], v[i].word);
    end

    // round-robin from reset: m0, m1, m0 with both masters requesting throughout
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    drive(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h080, 32'h0, 4'h0);
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) begin
        check($sformatf("rr%0d_mem_req", c), {31'h0, mem_req}, 32'h1);
        check($sformatf("rr%0d_mem_addr", c), mem_addr, (c % 4 == 0) ? 32'h100 : 32'h080);
        check($sformatf("rr%0d_acks", c), {30'h0, m1_ack, m0_ack}, 32'h0);
        check($sformatf("rr%0d_holds", c), {30'h0, m1_hold, m0_hold}, 32'h3);
      end else begin
        check($sformatf("rr%0d_m0_ack", c), {31'h0, m0_ack}, (c % 4 == 1) ? 32'h1 : 32'h0);
        check($sformatf("rr%0d_m1_ack", c), {31'h0, m1_ack}, (c % 4 == 3) ? 32'h1 : 32'h0);
        check($sformatf("rr%0d_m0_rdata", c), m0_rdata, (c % 4 == 1) ? 32'hDEADBEEF : 32'h0);
        check($sformatf("rr%0d_m1_rdata", c), m1_rdata, (c % 4 == 3) ? 32'hCAFEF00D : 32'h0);
      end
      tick;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick;
    tick;

    // fixed priority: m0 starves m1 across 20 back-to-back transactions
    fp_acks = 0;
    drive(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h080, 32'h0, 4'h0);
    #1;
    for (int c = 0; c < 40; c++) begin
      check($sformatf("fp%0d_m1_ack", c), {31'h0, fp_m1_ack}, 32'h0);
      check($sformatf("fp%0d_m1_hold", c), {31'h0, fp_m1_hold}, 32'h1);
      if (fp_m0_ack) fp_acks++;
      tick;
    end
    check("fp_m0_ack_count", fp_acks, 32'd20);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick;
    tick;

    // reset landing in the RMW cycle must abort the write
    drive(1'b0, 1'b1, 32'h040, 32'h0000BB00, 4'h2);
    #1;
    check("rmwrst_t0_mem_req", {31'h0, mem_req}, 32'h1);
    check("rmwrst_t0_mem_we", {31'h0, mem_we}, 32'h0);
    tick;
    check("rmwrst_t1_mem_we", {31'h0, mem_we}, 32'h1);
    check("rmwrst_t1_mem_wdata", mem_wdata, 32'h55AABB66);
    rst_n = 1'b0;
    #1;
    check("rmwrst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rmwrst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rmwrst_m0_ack", {31'h0, m0_ack}, 32'h0);
    check("rmwrst_busy", {31'h0, busy}, 32'h0);
    m0_req = 1'b0;
    tick;
    check("rmwrst_ram_word", ram[8'h10], 32'h55AA3366);
    rst_n = 1'b1;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
